cmadd_arbiter: RTL and testbench
================================

Name: cmadd_arbiter

Overview:
- Round-robin arbiter that shares one complex matrix add datapath between NREQ requesters.
- Per-requester valid/ready request channels are muxed onto the datapath's single input handshake.
- The requester index of every accepted job is recorded in an in-order tag FIFO.
- Each datapath result is steered back to the requester that issued it. The block sits between the requester cores and the complex matrix add unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- OP_W, 4096, operand bundle width per job (16 elements x {b2,a2,b1,a1} x 64 bit).
- RES_W, 2048, result bundle width per job.
- MAX_OUT, 4, tag FIFO depth = maximum jobs in flight (power of two, >=2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NREQ  request valid per requester.
- req_ready_o  out  NREQ  request accepted per requester.
- req_sub_i  in  NREQ  per-requester subtract select.
- req_operands_i  in  NREQ x OP_W  per-requester operand bundle.
- rsp_valid_o  out  NREQ  result valid per requester.
- rsp_ready_i  in  NREQ  result ready per requester.
- rsp_result_o  out  RES_W  shared result bus (meaningful only with rsp_valid_o).
- dp_in_valid_o  out  1  to datapath in_valid_i.
- dp_in_ready_i  in  1  from datapath in_ready_o.
- dp_sub_o  out  1  to datapath sub.
- dp_operands_o  out  OP_W  to datapath operands_i.
- dp_out_valid_i  in  1  from datapath out_valid_o.
- dp_out_ready_o  out  1  to datapath out_ready_i.
- dp_result_i  in  RES_W  from datapath result_o.
- dp_busy_i  in  1  from datapath busy_o.
- flush_i  in  1  synchronous flush.
- dp_flush_o  out  1  to datapath flush_i.
- outstanding_o  out  clog2(MAX_OUT)+1  jobs in flight.
- busy_o  out  1  outstanding_o!=0 or dp_busy_i.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_ni=0): RR pointer=0, lock cleared, FIFO empty, outstanding_o=0, err_o=0. All valid/ready outputs are 0 while in reset.
- Arbitration:
  - Combinational, zero-cycle pass-through.
  - The candidate is the first requester with req_valid_i set, searching from the RR pointer upward with wrap.
  - The grant is issued only if the FIFO is not full.
  - dp_in_valid_o = grant exists and not flush_i.
  - dp_operands_o and dp_sub_o come from the granted requester; they are 0 when there is no grant.
- Ready and handshake:
  - req_ready_o[g] = dp_in_ready_i for the granted g only; every other bit is 0.
  - Handshake = dp_in_valid_o & dp_in_ready_i.
  - On handshake: push g into the FIFO, set RR pointer = (g+1) mod NREQ, clear the lock.
- Lock: if dp_in_valid_o=1 and dp_in_ready_i=0, the lock register captures g. The grant stays on g until the handshake completes, even if a higher-priority requester asserts.
- Full FIFO: no grant, even if a pop occurs in the same cycle. The next cycle re-evaluates.
- Response path:
  - head = FIFO head tag.
  - rsp_valid_o[head] = dp_out_valid_i & FIFO non-empty.
  - dp_out_ready_o = rsp_ready_i[head] when non-empty, else 0.
  - rsp_result_o = dp_result_i.
  - On dp_out_valid_i & dp_out_ready_o: pop.
- Simultaneous push and pop: outstanding_o stays unchanged; pointers advance correctly.
- Protocol error: dp_out_valid_i=1 while the FIFO is empty sets err_o=1. err_o holds until reset, and no rsp_valid_o is asserted.
- Flush (flush_i=1):
  - dp_flush_o=1 in the same cycle.
  - No handshake occurs that cycle.
  - Next cycle: FIFO empty, lock cleared, outstanding_o=0.
  - RR pointer and err_o are preserved.
- Responses return strictly in issue order; the datapath is in-order.
- outstanding_o is registered and reflects pushes/pops of the previous cycle.

Test Plan:
- Single requester: NREQ=4, only req 2 valid, dp_in_ready_i=1. Expect req_ready_o=4'b0100 same cycle, FIFO tag 2. Result returned with rsp_ready_i[2]=1 -> rsp_valid_o=4'b0100, outstanding 1->0.
- Round-robin: all 4 valid for 8 cycles, dp ready constant. Grant order is 0,1,2,3,0,1,2,3, and each response lands on the matching rsp_valid_o bit in that order.
- Lock: req 1 granted with dp_in_ready_i=0 for 3 cycles while req 0 asserts. dp_operands_o holds req 1's bundle throughout. Req 1 is accepted first, then req 0 is granted next.
- FIFO full: MAX_OUT=4, no results returned. After 4 accepts, dp_in_valid_o=0 with requests pending. A pop in the same cycle still gives no grant that cycle, and a grant is issued the following cycle.
- Backpressure: head tag 3, rsp_ready_i[3]=0 for 2 cycles. dp_out_ready_o=0 for those cycles and is released when rsp_ready_i[3]=1. Other requesters' rsp_ready_i are ignored.
- Flush/error: 3 jobs in flight, pulse flush_i -> dp_flush_o=1, outstanding_o=0 next cycle. A subsequent dp_out_valid_i=1 with the FIFO empty -> err_o=1 and stays 1 until rst_ni=0, which also clears err_o asynchronously.

Source files
------------

// File: rtl/cmadd_arbiter.sv
// cmadd_arbiter: round-robin arbiter sharing one complex matrix add datapath
// between NREQ requesters.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    per-requester job handshake
//   req_sub_i, req_operands_i  per-requester subtract select and operand bundle
//   rsp_valid_o/rsp_ready_i    per-requester result handshake
//   rsp_result_o               shared result bus (qualified by rsp_valid_o)
//   dp_*                       datapath input/output handshakes, flush, busy
//   flush_i                    synchronous flush (drops all in-flight tags)
//   outstanding_o              registered count of jobs in flight
//   busy_o                     jobs in flight or datapath busy
//   err_o                      sticky: datapath result arrived with no tag
module cmadd_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned OP_W    = 4096,
   parameter int unsigned RES_W   = 2048,
   parameter int unsigned MAX_OUT = 4,
   localparam int unsigned IDX_W  = $clog2(NREQ),
   localparam int unsigned PTR_W  = $clog2(MAX_OUT),
   localparam int unsigned CNT_W  = PTR_W + 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NREQ-1:0]                req_valid_i,
   output logic [NREQ-1:0]                req_ready_o,
   input  logic [NREQ-1:0]                req_sub_i,
   input  logic [NREQ-1:0][OP_W-1:0]      req_operands_i,
   output logic [NREQ-1:0]                rsp_valid_o,
   input  logic [NREQ-1:0]                rsp_ready_i,
   output logic [RES_W-1:0]               rsp_result_o,
   output logic                           dp_in_valid_o,
   input  logic                           dp_in_ready_i,
   output logic                           dp_sub_o,
   output logic [OP_W-1:0]                dp_operands_o,
   input  logic                           dp_out_valid_i,
   output logic                           dp_out_ready_o,
   input  logic [RES_W-1:0]               dp_result_i,
   input  logic                           dp_busy_i,
   input  logic                           flush_i,
   output logic                           dp_flush_o,
   output logic [CNT_W-1:0]               outstanding_o,
   output logic                           busy_o,
   output logic                           err_o
);

   logic [IDX_W-1:0]                rr_q, rr_d;
   logic                            lock_q, lock_d;
   logic [IDX_W-1:0]                lock_idx_q, lock_idx_d;
   logic [MAX_OUT-1:0][IDX_W-1:0]   tag_q, tag_d;
   logic [PTR_W-1:0]                wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic                            err_q, err_d;

   logic                            cand_found;
   logic [IDX_W-1:0]                cand_idx;
   logic [IDX_W:0]                  rr_sum;
   logic                            grant_valid;
   logic [IDX_W-1:0]                grant_idx;
   logic                            full, empty;
   logic [IDX_W-1:0]                head;
   logic                            hs, pop;

   assign full  = (cnt_q == CNT_W'(MAX_OUT));
   assign empty = (cnt_q == '0);
   assign head  = tag_q[rd_q];

   // Round-robin search starting at rr_q, wrapping modulo NREQ.
   always_comb begin
      cand_found = 1'b0;
      cand_idx   = '0;
      rr_sum     = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         rr_sum = {1'b0, rr_q} + (IDX_W+1)'(i);
         if (rr_sum >= (IDX_W+1)'(NREQ)) begin
            rr_sum = rr_sum - (IDX_W+1)'(NREQ);
         end
         if (!cand_found && req_valid_i[rr_sum[IDX_W-1:0]]) begin
            cand_found = 1'b1;
            cand_idx   = rr_sum[IDX_W-1:0];
         end
      end
   end

   // A stalled grant stays put until its handshake, regardless of priority.
   always_comb begin
      grant_idx   = cand_idx;
      grant_valid = cand_found;
      if (lock_q && req_valid_i[lock_idx_q]) begin
         grant_idx   = lock_idx_q;
         grant_valid = 1'b1;
      end
      // Full is judged on the registered count: a same-cycle pop does not help.
      grant_valid = grant_valid & ~full & rst_ni;
   end

   always_comb begin
      dp_in_valid_o = grant_valid & ~flush_i;
      req_ready_o   = '0;
      if (dp_in_valid_o) begin
         req_ready_o[grant_idx] = dp_in_ready_i;
      end
      dp_operands_o = grant_valid ? req_operands_i[grant_idx] : '0;
      dp_sub_o      = grant_valid ? req_sub_i[grant_idx] : 1'b0;

      rsp_valid_o = '0;
      if (dp_out_valid_i && !empty) begin
         rsp_valid_o[head] = 1'b1;
      end
      dp_out_ready_o = ~empty & rsp_ready_i[head];
   end

   assign hs            = dp_in_valid_o & dp_in_ready_i;
   assign pop           = dp_out_valid_i & dp_out_ready_o;
   assign rsp_result_o  = dp_result_i;
   assign dp_flush_o    = flush_i;
   assign outstanding_o = cnt_q;
   assign busy_o        = (cnt_q != '0) | dp_busy_i;
   assign err_o         = err_q;

   always_comb begin
      rr_d       = rr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      tag_d      = tag_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      err_d      = err_q | (dp_out_valid_i & empty);

      if (flush_i) begin
         lock_d = 1'b0;
         wr_d   = '0;
         rd_d   = '0;
         cnt_d  = '0;
      end else begin
         if (hs) begin
            tag_d[wr_q] = grant_idx;
            wr_d        = wr_q + 1'b1;
            lock_d      = 1'b0;
            rr_d        = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
         end else if (dp_in_valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = grant_idx;
         end
         if (pop) begin
            rd_d = rd_q + 1'b1;
         end
         unique case ({hs, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q       <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         tag_q      <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         rr_q       <= rr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         tag_q      <= tag_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_cmadd_arbiter.sv
module tb_cmadd_arbiter;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned OP_W    = 16;
   localparam int unsigned RES_W   = 8;
   localparam int unsigned MAX_OUT = 4;

   logic                       clk_i = 1'b0;
   logic                       rst_ni;
   logic [NREQ-1:0]            req_valid_i;
   logic [NREQ-1:0]            req_ready_o;
   logic [NREQ-1:0]            req_sub_i;
   logic [NREQ-1:0][OP_W-1:0]  req_operands_i;
   logic [NREQ-1:0]            rsp_valid_o;
   logic [NREQ-1:0]            rsp_ready_i;
   logic [RES_W-1:0]           rsp_result_o;
   logic                       dp_in_valid_o;
   logic                       dp_in_ready_i;
   logic                       dp_sub_o;
   logic [OP_W-1:0]            dp_operands_o;
   logic                       dp_out_valid_i;
   logic                       dp_out_ready_o;
   logic [RES_W-1:0]           dp_result_i;
   logic                       dp_busy_i;
   logic                       flush_i;
   logic                       dp_flush_o;
   logic [2:0]                 outstanding_o;
   logic                       busy_o;
   logic                       err_o;

   cmadd_arbiter #(
      .NREQ    (NREQ),
      .OP_W    (OP_W),
      .RES_W   (RES_W),
      .MAX_OUT (MAX_OUT)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_sub_i      (req_sub_i),
      .req_operands_i (req_operands_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_ready_i    (rsp_ready_i),
      .rsp_result_o   (rsp_result_o),
      .dp_in_valid_o  (dp_in_valid_o),
      .dp_in_ready_i  (dp_in_ready_i),
      .dp_sub_o       (dp_sub_o),
      .dp_operands_o  (dp_operands_o),
      .dp_out_valid_i (dp_out_valid_i),
      .dp_out_ready_o (dp_out_ready_o),
      .dp_result_i    (dp_result_i),
      .dp_busy_i      (dp_busy_i),
      .flush_i        (flush_i),
      .dp_flush_o     (dp_flush_o),
      .outstanding_o  (outstanding_o),
      .busy_o         (busy_o),
      .err_o          (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0] rv;
      logic       dir;
      logic       dov;
      logic [3:0] rrd;
      logic       fl;
      logic [3:0] erdy;
      logic       ediv;
      int         eg;     // expected granted requester, -1 for none
      logic [3:0] ersv;
      logic       edor;
      logic [2:0] eout;
      logic       eerr;
   } vec_t;

   vec_t            vq[$];
   logic [OP_W-1:0] ops [NREQ];
   logic [NREQ-1:0] sub_pat;
   int              checks = 0;
   int              errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic add(input int rv, input int dir, input int dov, input int rrd, input int fl,
                      input int erdy, input int ediv, input int eg, input int ersv,
                      input int edor, input int eout, input int eerr);
      vec_t v;
      v.rv   = 4'(rv);
      v.dir  = 1'(dir);
      v.dov  = 1'(dov);
      v.rrd  = 4'(rrd);
      v.fl   = 1'(fl);
      v.erdy = 4'(erdy);
      v.ediv = 1'(ediv);
      v.eg   = eg;
      v.ersv = 4'(ersv);
      v.edor = 1'(edor);
      v.eout = 3'(eout);
      v.eerr = 1'(eerr);
      vq.push_back(v);
   endtask

   task automatic idle_inputs();
      req_valid_i    = '0;
      dp_in_ready_i  = 1'b0;
      dp_out_valid_i = 1'b0;
      rsp_ready_i    = '0;
      flush_i        = 1'b0;
      dp_busy_i      = 1'b0;
   endtask

   initial begin
      vec_t            v;
      logic [OP_W-1:0] exp_op;
      logic            exp_sub;

      sub_pat = 4'b1010;
      for (int i = 0; i < int'(NREQ); i++) begin
         ops[i]            = 16'hA000 + 16'(i) * 16'h0111;
         req_operands_i[i] = ops[i];
      end
      req_sub_i   = sub_pat;
      dp_result_i = 8'h5A;
      idle_inputs();
      rst_ni = 1'b0;

      // While in reset, requests must not leak through.
      @(negedge clk_i);
      req_valid_i   = 4'b1111;
      dp_in_ready_i = 1'b1;
      #2;
      chk("rst_dp_in_valid", 32'(dp_in_valid_o), 32'd0);
      chk("rst_req_ready", 32'(req_ready_o), 32'd0);
      chk("rst_outstanding", 32'(outstanding_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      @(negedge clk_i);
      idle_inputs();
      rst_ni = 1'b1;

      //  rv      dir dov rrd     fl  erdy    div eg  ersv    dor out err
      // Round robin with one-cycle-lagged in-order responses
      add('b1111, 1, 0, 'b1111, 0, 'b0001, 1,  0, 'b0000, 0, 0, 0);
      add('b1111, 1, 1, 'b1111, 0, 'b0010, 1,  1, 'b0001, 1, 1, 0);
      add('b1111, 1, 1, 'b1111, 0, 'b0100, 1,  2, 'b0010, 1, 1, 0);
      add('b1111, 1, 1, 'b1111, 0, 'b1000, 1,  3, 'b0100, 1, 1, 0);
      add('b1111, 1, 1, 'b1111, 0, 'b0001, 1,  0, 'b1000, 1, 1, 0);
      add('b1111, 1, 1, 'b1111, 0, 'b0010, 1,  1, 'b0001, 1, 1, 0);
      add('b1111, 1, 1, 'b1111, 0, 'b0100, 1,  2, 'b0010, 1, 1, 0);
      add('b1111, 1, 1, 'b1111, 0, 'b1000, 1,  3, 'b0100, 1, 1, 0);
      add('b0000, 1, 1, 'b1111, 0, 'b0000, 0, -1, 'b1000, 1, 1, 0);
      // Single requester 2
      add('b0100, 1, 0, 'b0100, 0, 'b0100, 1,  2, 'b0000, 0, 0, 0);
      add('b0000, 1, 1, 'b0100, 0, 'b0000, 0, -1, 'b0100, 1, 1, 0);
      add('b0000, 0, 0, 'b0000, 0, 'b0000, 0, -1, 'b0000, 0, 0, 0);
      // Lock on req 1 while req 0 (higher priority from rr=3) asserts
      add('b0010, 0, 0, 'b0000, 0, 'b0000, 1,  1, 'b0000, 0, 0, 0);
      add('b0011, 0, 0, 'b0000, 0, 'b0000, 1,  1, 'b0000, 0, 0, 0);
      add('b0011, 0, 0, 'b0000, 0, 'b0000, 1,  1, 'b0000, 0, 0, 0);
      add('b0011, 1, 0, 'b0000, 0, 'b0010, 1,  1, 'b0000, 0, 0, 0);
      add('b0001, 1, 0, 'b0000, 0, 'b0001, 1,  0, 'b0000, 0, 1, 0);
      add('b0000, 0, 1, 'b1111, 0, 'b0000, 0, -1, 'b0010, 1, 2, 0);
      add('b0000, 0, 1, 'b1111, 0, 'b0000, 0, -1, 'b0001, 1, 1, 0);
      // Fill FIFO, then full with and without same-cycle pop
      add('b1111, 1, 0, 'b0000, 0, 'b0010, 1,  1, 'b0000, 0, 0, 0);
      add('b1111, 1, 0, 'b0000, 0, 'b0100, 1,  2, 'b0000, 0, 1, 0);
      add('b1111, 1, 0, 'b0000, 0, 'b1000, 1,  3, 'b0000, 0, 2, 0);
      add('b1111, 1, 0, 'b0000, 0, 'b0001, 1,  0, 'b0000, 0, 3, 0);
      add('b1111, 1, 0, 'b0000, 0, 'b0000, 0, -1, 'b0000, 0, 4, 0);
      add('b1111, 1, 1, 'b1111, 0, 'b0000, 0, -1, 'b0010, 1, 4, 0);
      add('b1111, 1, 0, 'b0000, 0, 'b0010, 1,  1, 'b0000, 0, 3, 0);
      // Backpressure on head tag 3; other readies ignored
      add('b0000, 0, 1, 'b1111, 0, 'b0000, 0, -1, 'b0100, 1, 4, 0);
      add('b0000, 0, 1, 'b0111, 0, 'b0000, 0, -1, 'b1000, 0, 3, 0);
      add('b0000, 0, 1, 'b0111, 0, 'b0000, 0, -1, 'b1000, 0, 3, 0);
      add('b0000, 0, 1, 'b1000, 0, 'b0000, 0, -1, 'b1000, 1, 3, 0);
      // Three in flight, flush; rr pointer (3) survives the flush
      add('b0100, 1, 0, 'b0000, 0, 'b0100, 1,  2, 'b0000, 0, 2, 0);
      add('b1111, 1, 0, 'b0000, 1, 'b0000, 0,  3, 'b0000, 0, 3, 0);
      add('b0000, 0, 0, 'b0000, 0, 'b0000, 0, -1, 'b0000, 0, 0, 0);
      add('b1111, 1, 0, 'b0000, 0, 'b1000, 1,  3, 'b0000, 0, 0, 0);
      add('b0000, 0, 1, 'b1111, 0, 'b0000, 0, -1, 'b1000, 1, 1, 0);
      // Stray result with empty FIFO -> sticky error
      add('b0000, 0, 1, 'b0000, 0, 'b0000, 0, -1, 'b0000, 0, 0, 0);
      add('b0000, 0, 0, 'b0000, 0, 'b0000, 0, -1, 'b0000, 0, 0, 1);
      add('b0000, 0, 0, 'b0000, 0, 'b0000, 0, -1, 'b0000, 0, 0, 1);

      for (int n = 0; n < vq.size(); n++) begin
         v = vq[n];
         @(negedge clk_i);
         req_valid_i    = v.rv;
         dp_in_ready_i  = v.dir;
         dp_out_valid_i = v.dov;
         rsp_ready_i    = v.rrd;
         flush_i        = v.fl;
         #2;
         exp_op  = (v.eg >= 0) ? ops[v.eg] : '0;
         exp_sub = (v.eg >= 0) ? sub_pat[v.eg] : 1'b0;
         chk($sformatf("v%0d req_ready", n), 32'(req_ready_o), 32'(v.erdy));
         chk($sformatf("v%0d dp_in_valid", n), 32'(dp_in_valid_o), 32'(v.ediv));
         chk($sformatf("v%0d dp_operands", n), 32'(dp_operands_o), 32'(exp_op));
         chk($sformatf("v%0d dp_sub", n), 32'(dp_sub_o), 32'(exp_sub));
         chk($sformatf("v%0d rsp_valid", n), 32'(rsp_valid_o), 32'(v.ersv));
         chk($sformatf("v%0d dp_out_ready", n), 32'(dp_out_ready_o), 32'(v.edor));
         chk($sformatf("v%0d outstanding", n), 32'(outstanding_o), 32'(v.eout));
         chk($sformatf("v%0d err", n), 32'(err_o), 32'(v.eerr));
         chk($sformatf("v%0d dp_flush", n), 32'(dp_flush_o), 32'(v.fl));
      end

      // Busy follows the datapath when nothing is in flight; result bus passes through.
      @(negedge clk_i);
      idle_inputs();
      dp_busy_i = 1'b1;
      #2;
      chk("busy_dp", 32'(busy_o), 32'd1);
      chk("rsp_result", 32'(rsp_result_o), 32'h5A);
      @(negedge clk_i);
      dp_busy_i   = 1'b0;
      dp_result_i = 8'hC3;
      #2;
      chk("busy_idle", 32'(busy_o), 32'd0);
      chk("rsp_result2", 32'(rsp_result_o), 32'hC3);
      chk("err_held", 32'(err_o), 32'd1);

      // Asynchronous reset mid-cycle clears err at once and gates requests.
      @(posedge clk_i);
      #2;
      req_valid_i   = 4'b1111;
      dp_in_ready_i = 1'b1;
      rst_ni        = 1'b0;
      #1;
      chk("arst_err", 32'(err_o), 32'd0);
      chk("arst_dp_in_valid", 32'(dp_in_valid_o), 32'd0);
      chk("arst_req_ready", 32'(req_ready_o), 32'd0);
      @(negedge clk_i);
      idle_inputs();
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("post_rst_err", 32'(err_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
